// File: rtl/ff_bank.sv
// Purpose : bank of WIDTH flip-flops sharing one clock, run-time selectable SR/JK/D/T behaviour.
// Latency : q updates one cycle after the sampling edge; qc is combinational from q.
// Backpr. : none; en=0 freezes the bank (q and illegal_cnt hold, pulses drop to 0).
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset (overrides every other input)
//   en          clock enable
//   mode        00=SR, 01=JK, 10=D, 11=T
//   a           per-bit S / J / D / T input
//   b           per-bit R / K input (unused in D and T modes)
//   q           registered flip-flop state
//   qc          ~q, combinational
//   changed     one-cycle pulse: q moved at the previous non-reset edge
//   illegal     one-cycle pulse: previous enabled SR edge had a&b on some bit
//   illegal_cnt saturating count of illegal edges
module ff_bank #(
    parameter int                 WIDTH   = 8,
    parameter int                 CNT_W   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qc,
    output logic             changed,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_e            mode_s;

    logic [WIDTH-1:0] q_q,           q_d;
    logic             changed_q,     changed_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;

    // Characteristic next state for an enabled edge, before reset/enable gating.
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] forbid_bits;

    assign mode_s = mode_e'(mode);

    // Per-bit characteristic equations, written as whole-bank bitwise logic.
    always_comb begin
        q_next      = q_q;
        forbid_bits = '0;
        unique case (mode_s)
            MODE_SR: begin
                // Set where a&~b, clear where ~a&b; a==b (00 hold, 11 forbidden) keeps q.
                q_next      = (q_q & ~(a ^ b)) | (a & ~b);
                forbid_bits = a & b;
            end
            MODE_JK: begin
                // Q+ = J&~Q | ~K&Q : 00 hold, 01 clear, 10 set, 11 toggle.
                q_next = (a & ~q_q) | (~b & q_q);
            end
            MODE_D: begin
                q_next = a;
            end
            MODE_T: begin
                q_next = q_q ^ a;
            end
            default: begin
                q_next = q_q;
            end
        endcase
    end

    // Gating by reset and enable; status pulses are derived here so the
    // sequential block is a plain register bank.
    always_comb begin
        q_d       = q_q;
        changed_d = 1'b0;
        illegal_d = 1'b0;
        cnt_d     = cnt_q;
        if (rst) begin
            // Reset edges never report a change even though q may move.
            q_d       = RST_VAL;
            changed_d = 1'b0;
            illegal_d = 1'b0;
            cnt_d     = '0;
        end else if (en) begin
            q_d       = q_next;
            changed_d = (q_next != q_q);
            // One count per illegal edge, no matter how many bits collided.
            illegal_d = |forbid_bits;
            if (illegal_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        q_q       <= q_d;
        changed_q <= changed_d;
        illegal_q <= illegal_d;
        cnt_q     <= cnt_d;
    end

    assign q           = q_q;
    assign qc          = ~q_q;
    assign changed     = changed_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule
